// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared types and constants for the PSRAM access controller
package psram_pkg;

    localparam int MEM_AW = 23;
    localparam int MEM_DW = 16;

    localparam logic RQ_RD = 1'b0;
    localparam logic RQ_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SNES_RD = 3'd1,
        ST_SNES_WR = 3'd2,
        ST_MCU_RD  = 3'd3,
        ST_MCU_WR  = 3'd4,
        ST_RECOVER = 3'd5
    } state_e;

    // Odd byte addresses live on the upper half of the 16-bit word.
    function automatic logic [7:0] lane_sel(input logic [MEM_DW-1:0] dq, input logic a0);
        return a0 ? dq[15:8] : dq[7:0];
    endfunction

endpackage

// File: rtl/psram_access_ctrl_if.sv
// rtl/psram_access_ctrl_if.sv - requester, decoder and PSRAM pad signals of the access controller
interface psram_access_ctrl_if;
    import psram_pkg::*;

    logic              SNES_RD_START;
    logic              SNES_WR_END;
    logic [23:0]       ROM_ADDR;
    logic              ROM_HIT;
    logic              IS_WRITABLE;
    logic [7:0]        SNES_DATA_IN;
    logic [7:0]        SNES_DATA_OUT;
    logic              MCU_RRQ;
    logic              MCU_WRQ;
    logic [23:0]       MCU_ADDR;
    logic [7:0]        MCU_DOUT;
    logic [7:0]        MCU_DINR;
    logic              MCU_RDY;
    logic [MEM_AW-1:0] MEM_ADDR;
    logic [MEM_DW-1:0] MEM_DQ_OUT;
    logic [MEM_DW-1:0] MEM_DQ_IN;
    logic              MEM_DQ_OE;
    logic              MEM_OE_N;
    logic              MEM_WE_N;
    logic              MEM_BHE_N;
    logic              MEM_BLE_N;

    modport slave (
        input  SNES_RD_START, SNES_WR_END, ROM_ADDR, ROM_HIT, IS_WRITABLE, SNES_DATA_IN,
        input  MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, MEM_DQ_IN,
        output SNES_DATA_OUT, MCU_DINR, MCU_RDY,
        output MEM_ADDR, MEM_DQ_OUT, MEM_DQ_OE, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N
    );

    modport master (
        output SNES_RD_START, SNES_WR_END, ROM_ADDR, ROM_HIT, IS_WRITABLE, SNES_DATA_IN,
        output MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_DOUT, MEM_DQ_IN,
        input  SNES_DATA_OUT, MCU_DINR, MCU_RDY,
        input  MEM_ADDR, MEM_DQ_OUT, MEM_DQ_OE, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N
    );

endinterface

// File: rtl/psram_cycle_timer.sv
// rtl/psram_cycle_timer.sv - loadable down-counter timing one PSRAM access
module psram_cycle_timer #(
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    output logic          done_o,
    output logic          busy_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            cnt_d = load_val_i;
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done_o = run_q && (cnt_q == '0);
    assign busy_o = run_q;

endmodule

// File: rtl/psram_access_ctrl.sv
// rtl/psram_access_ctrl.sv - arbitrates SNES and MCU requests and runs timed PSRAM cycles
module psram_access_ctrl
    import psram_pkg::*;
#(
    parameter int RD_WAIT = 4,
    parameter int WR_WAIT = 4
) (
    input logic                CLK,
    input logic                RST,
    psram_access_ctrl_if.slave bus
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WR_WAIT - 1);

    state_e state_q, state_d;

    logic        snes_pend_q, snes_pend_d, snes_kind_q, snes_kind_d;
    logic [23:0] snes_addr_q, snes_addr_d;
    logic [7:0]  snes_data_q, snes_data_d;
    logic        mcu_pend_q, mcu_pend_d, mcu_kind_q, mcu_kind_d;
    logic [23:0] mcu_addr_q, mcu_addr_d;
    logic [7:0]  mcu_data_q, mcu_data_d;
    logic        mcu_rdy_q, mcu_rdy_d, mcu_op_q, mcu_op_d, op_a0_q, op_a0_d;

    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [MEM_DW-1:0] dq_out_q, dq_out_d;
    logic dq_oe_q, dq_oe_d, oe_n_q, oe_n_d, we_n_q, we_n_d, bhe_n_q, bhe_n_d, ble_n_q, ble_n_d;
    logic [7:0] snes_dout_q, snes_dout_d, mcu_dinr_q, mcu_dinr_d;

    logic snes_rd_evt, snes_wr_evt, snes_evt, evt_kind, mcu_req, mcu_req_kind;
    logic sn_kind, mc_kind, take_snes, take_mcu, tmr_load, tmr_done, tmr_busy, rd_d, wr_d;
    logic [23:0] sn_addr, mc_addr, op_addr;
    logic [7:0]  sn_data, mc_data, op_data;
    logic [CW-1:0] tmr_val;

    assign snes_rd_evt  = bus.SNES_RD_START & bus.ROM_HIT;
    assign snes_wr_evt  = bus.SNES_WR_END & bus.IS_WRITABLE;
    assign snes_evt     = snes_rd_evt | snes_wr_evt;
    assign evt_kind     = snes_wr_evt ? RQ_WR : RQ_RD;
    assign mcu_req      = (bus.MCU_RRQ | bus.MCU_WRQ) & mcu_rdy_q;
    assign mcu_req_kind = bus.MCU_WRQ ? RQ_WR : RQ_RD;

    // A same-cycle event supersedes the pending slot; the MCU slot is empty whenever a request is accepted.
    assign sn_kind = snes_evt ? evt_kind : snes_kind_q;
    assign sn_addr = snes_evt ? bus.ROM_ADDR : snes_addr_q;
    assign sn_data = snes_evt ? bus.SNES_DATA_IN : snes_data_q;
    assign mc_kind = mcu_pend_q ? mcu_kind_q : mcu_req_kind;
    assign mc_addr = mcu_pend_q ? mcu_addr_q : bus.MCU_ADDR;
    assign mc_data = mcu_pend_q ? mcu_data_q : bus.MCU_DOUT;
    assign op_addr = take_snes ? sn_addr : mc_addr;
    assign op_data = take_snes ? sn_data : mc_data;

    psram_cycle_timer #(.CW(CW)) u_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done),
        .busy_o     (tmr_busy)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        take_snes = 1'b0;
        take_mcu  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!tmr_busy) begin
                    if (snes_evt || snes_pend_q) begin
                        take_snes = 1'b1;
                        state_d   = (sn_kind == RQ_WR) ? ST_SNES_WR : ST_SNES_RD;
                    end else if (mcu_pend_q || mcu_req) begin
                        take_mcu = 1'b1;
                        state_d  = (mc_kind == RQ_WR) ? ST_MCU_WR : ST_MCU_RD;
                    end
                end
            end
            ST_SNES_RD, ST_SNES_WR, ST_MCU_RD, ST_MCU_WR: begin
                if (tmr_done) state_d = ST_RECOVER;
            end
            ST_RECOVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_d     = (state_d == ST_SNES_RD) || (state_d == ST_MCU_RD);
        wr_d     = (state_d == ST_SNES_WR) || (state_d == ST_MCU_WR);
        tmr_load = take_snes | take_mcu;
        tmr_val  = rd_d ? RD_LOAD : WR_LOAD;
        op_a0_d  = tmr_load ? op_addr[0] : op_a0_q;
        mcu_op_d = tmr_load ? take_mcu : mcu_op_q;

        mem_addr_d = tmr_load ? op_addr[23:1] : mem_addr_q;
        dq_out_d   = tmr_load ? {op_data, op_data} : dq_out_q;
        oe_n_d     = !rd_d;
        // Write strobe skips the first state cycle so the address is settled before WE falls.
        we_n_d     = !(wr_d && (state_q == state_d));
        dq_oe_d    = wr_d;
        bhe_n_d    = !(rd_d || (wr_d && op_a0_d));
        ble_n_d    = !(rd_d || (wr_d && !op_a0_d));

        snes_dout_d = snes_dout_q;
        mcu_dinr_d  = mcu_dinr_q;
        if (tmr_done && (state_q == ST_SNES_RD)) snes_dout_d = lane_sel(bus.MEM_DQ_IN, op_a0_q);
        if (tmr_done && (state_q == ST_MCU_RD))  mcu_dinr_d  = lane_sel(bus.MEM_DQ_IN, op_a0_q);
    end

    always_comb begin
        snes_pend_d = snes_pend_q;
        snes_kind_d = snes_kind_q;
        snes_addr_d = snes_addr_q;
        snes_data_d = snes_data_q;
        if (take_snes) begin
            snes_pend_d = 1'b0;
        end else if (snes_evt) begin
            snes_pend_d = 1'b1;
            snes_kind_d = evt_kind;
            snes_addr_d = bus.ROM_ADDR;
            snes_data_d = bus.SNES_DATA_IN;
        end

        mcu_pend_d = mcu_pend_q;
        mcu_kind_d = mcu_kind_q;
        mcu_addr_d = mcu_addr_q;
        mcu_data_d = mcu_data_q;
        if (take_mcu) begin
            mcu_pend_d = 1'b0;
        end else if (mcu_req) begin
            mcu_pend_d = 1'b1;
            mcu_kind_d = mcu_req_kind;
            mcu_addr_d = bus.MCU_ADDR;
            mcu_data_d = bus.MCU_DOUT;
        end

        mcu_rdy_d = mcu_rdy_q;
        if (mcu_req) mcu_rdy_d = 1'b0;
        else if ((state_q == ST_RECOVER) && mcu_op_q) mcu_rdy_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            snes_pend_q <= 1'b0;
            snes_kind_q <= RQ_RD;
            snes_addr_q <= '0;
            snes_data_q <= '0;
            mcu_pend_q  <= 1'b0;
            mcu_kind_q  <= RQ_RD;
            mcu_addr_q  <= '0;
            mcu_data_q  <= '0;
            mcu_rdy_q   <= 1'b1;
            mcu_op_q    <= 1'b0;
            op_a0_q     <= 1'b0;
            mem_addr_q  <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            bhe_n_q     <= 1'b1;
            ble_n_q     <= 1'b1;
            snes_dout_q <= '0;
            mcu_dinr_q  <= '0;
        end else begin
            snes_pend_q <= snes_pend_d;
            snes_kind_q <= snes_kind_d;
            snes_addr_q <= snes_addr_d;
            snes_data_q <= snes_data_d;
            mcu_pend_q  <= mcu_pend_d;
            mcu_kind_q  <= mcu_kind_d;
            mcu_addr_q  <= mcu_addr_d;
            mcu_data_q  <= mcu_data_d;
            mcu_rdy_q   <= mcu_rdy_d;
            mcu_op_q    <= mcu_op_d;
            op_a0_q     <= op_a0_d;
            mem_addr_q  <= mem_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            bhe_n_q     <= bhe_n_d;
            ble_n_q     <= ble_n_d;
            snes_dout_q <= snes_dout_d;
            mcu_dinr_q  <= mcu_dinr_d;
        end
    end

    assign bus.SNES_DATA_OUT = snes_dout_q;
    assign bus.MCU_DINR      = mcu_dinr_q;
    assign bus.MCU_RDY       = mcu_rdy_q;
    assign bus.MEM_ADDR      = mem_addr_q;
    assign bus.MEM_DQ_OUT    = dq_out_q;
    assign bus.MEM_DQ_OE     = dq_oe_q;
    assign bus.MEM_OE_N      = oe_n_q;
    assign bus.MEM_WE_N      = we_n_q;
    assign bus.MEM_BHE_N     = bhe_n_q;
    assign bus.MEM_BLE_N     = ble_n_q;

endmodule

// File: tb/tb_psram_access_ctrl.sv
// tb/tb_psram_access_ctrl.sv - scoreboard bench for psram_access_ctrl
module tb_psram_access_ctrl;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    typedef struct packed {
        logic        is_wr;
        logic        to_mcu;
        logic [22:0] addr;
        logic        bhe_n;
        logic        ble_n;
        logic [3:0]  len;
        logic        drv;
        logic [15:0] data;
    } txn_t;

    txn_t exp_q[$];

    psram_access_ctrl_if bus();

    psram_access_ctrl #(.RD_WAIT(4), .WR_WAIT(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic txn_t mk(input logic is_wr, input logic to_mcu, input logic [23:0] baddr,
                                input logic [15:0] data);
        txn_t t;
        t.is_wr  = is_wr;
        t.to_mcu = to_mcu;
        t.addr   = baddr[23:1];
        t.bhe_n  = is_wr ? !baddr[0] : 1'b0;
        t.ble_n  = is_wr ? baddr[0] : 1'b0;
        t.len    = is_wr ? 4'd3 : 4'd4;
        t.drv    = is_wr;
        t.data   = data;
        return t;
    endfunction

    // Monitor: one scoreboard entry per completed strobe run.
    int   oe_run, we_run;
    txn_t r_got, w_got;

    task automatic score(input txn_t got_in);
        txn_t e, g;
        g = got_in;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_access: got %h required none", g);
        end else begin
            e = exp_q.pop_front();
            if (!g.is_wr) begin
                g.to_mcu = e.to_mcu;
                g.data   = {8'h00, e.to_mcu ? bus.MCU_DINR : bus.SNES_DATA_OUT};
            end
            if (g !== e) begin
                miscompares++;
                $display("FAIL access: got %h required %h", g, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            oe_run = 0;
            we_run = 0;
        end else begin
            if (!bus.MEM_OE_N) begin
                if (oe_run == 0) begin
                    r_got = '0;
                    r_got.addr  = bus.MEM_ADDR;
                    r_got.bhe_n = bus.MEM_BHE_N;
                    r_got.ble_n = bus.MEM_BLE_N;
                end
                r_got.drv = r_got.drv | bus.MEM_DQ_OE;
                oe_run++;
            end else if (oe_run != 0) begin
                r_got.len = 4'(oe_run);
                oe_run = 0;
                score(r_got);
            end
            if (!bus.MEM_WE_N) begin
                if (we_run == 0) begin
                    w_got = '0;
                    w_got.is_wr = 1'b1;
                    w_got.drv   = 1'b1;
                    w_got.addr  = bus.MEM_ADDR;
                    w_got.bhe_n = bus.MEM_BHE_N;
                    w_got.ble_n = bus.MEM_BLE_N;
                    w_got.data  = bus.MEM_DQ_OUT;
                end
                w_got.drv = w_got.drv & bus.MEM_DQ_OE;
                we_run++;
            end else if (we_run != 0) begin
                w_got.len = 4'(we_run);
                w_got.drv = w_got.drv & !bus.MEM_DQ_OE;
                we_run = 0;
                w_got.to_mcu = exp_q.size() != 0 ? exp_q[0].to_mcu : 1'b0;
                score(w_got);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus.SNES_RD_START = 1'b0;
        bus.SNES_WR_END   = 1'b0;
        bus.MCU_RRQ       = 1'b0;
        bus.MCU_WRQ       = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_snes_rd(input logic [23:0] a);
        bus.SNES_RD_START = 1'b1;
        bus.ROM_HIT       = 1'b1;
        bus.ROM_ADDR      = a;
    endtask

    task automatic set_snes_wr(input logic [23:0] a, input logic [7:0] d, input logic wok);
        bus.SNES_WR_END  = 1'b1;
        bus.ROM_HIT      = 1'b0;
        bus.IS_WRITABLE  = wok;
        bus.ROM_ADDR     = a;
        bus.SNES_DATA_IN = d;
    endtask

    task automatic set_mcu(input logic wr, input logic [23:0] a, input logic [7:0] d);
        bus.MCU_RRQ  = !wr;
        bus.MCU_WRQ  = wr;
        bus.MCU_ADDR = a;
        bus.MCU_DOUT = d;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        oe_run = 0;
        we_run = 0;
        rst = 1'b1;
        bus.SNES_RD_START = 1'b0;
        bus.SNES_WR_END   = 1'b0;
        bus.ROM_ADDR      = '0;
        bus.ROM_HIT       = 1'b0;
        bus.IS_WRITABLE   = 1'b0;
        bus.SNES_DATA_IN  = '0;
        bus.MCU_RRQ       = 1'b0;
        bus.MCU_WRQ       = 1'b0;
        bus.MCU_ADDR      = '0;
        bus.MCU_DOUT      = '0;
        bus.MEM_DQ_IN     = '0;
        cyc(3);
        chk("rst_snes_dout", 32'(bus.SNES_DATA_OUT), 32'h00);
        chk("rst_mcu_dinr",  32'(bus.MCU_DINR), 32'h00);
        chk("rst_mcu_rdy",   32'(bus.MCU_RDY), 32'h1);
        chk("rst_mem_addr",  32'(bus.MEM_ADDR), 32'h0);
        chk("rst_dq_oe",     32'(bus.MEM_DQ_OE), 32'h0);
        chk("rst_strobes",   {28'h0, bus.MEM_OE_N, bus.MEM_WE_N, bus.MEM_BHE_N, bus.MEM_BLE_N}, 32'hF);
        rst = 1'b0;
        cyc(2);

        // 1: idle SNES read, latency RD_WAIT+1
        bus.MEM_DQ_IN = 16'hAB12;
        exp_q.push_back(mk(1'b0, 1'b0, 24'h012345, 16'h00AB));
        set_snes_rd(24'h012345);
        step();
        cyc(3);
        chk("t1_dout_early", 32'(bus.SNES_DATA_OUT), 32'h00);
        cyc(1);
        chk("t1_dout_lat", 32'(bus.SNES_DATA_OUT), 32'hAB);
        cyc(5);

        // 2: writable and non-writable SNES writes
        exp_q.push_back(mk(1'b1, 1'b0, 24'hE00010, 16'h5A5A));
        set_snes_wr(24'hE00010, 8'h5A, 1'b1);
        step();
        cyc(10);
        set_snes_wr(24'hE00010, 8'h5A, 1'b0);
        step();
        cyc(10);

        // 3: MCU read, SNES read arrives during it
        bus.MEM_DQ_IN = 16'hC37E;
        exp_q.push_back(mk(1'b0, 1'b1, 24'h000001, 16'h00C3));
        exp_q.push_back(mk(1'b0, 1'b0, 24'h000200, 16'h007E));
        set_mcu(1'b0, 24'h000001, 8'h00);
        step();
        chk("t3_rdy_busy", 32'(bus.MCU_RDY), 32'h0);
        set_snes_rd(24'h000200);
        step();
        cyc(18);
        chk("t3_rdy_after", 32'(bus.MCU_RDY), 32'h1);

        // 4: MCU write and SNES read in the same idle cycle
        bus.MEM_DQ_IN = 16'h1234;
        exp_q.push_back(mk(1'b0, 1'b0, 24'h000042, 16'h0034));
        exp_q.push_back(mk(1'b1, 1'b1, 24'h000101, 16'h9696));
        set_mcu(1'b1, 24'h000101, 8'h96);
        set_snes_rd(24'h000042);
        step();
        chk("t4_rdy_busy", 32'(bus.MCU_RDY), 32'h0);
        cyc(22);
        chk("t4_rdy_after", 32'(bus.MCU_RDY), 32'h1);

        // 5: two SNES reads during an MCU op (latest wins); MCU request while busy ignored
        bus.MEM_DQ_IN = 16'h55AA;
        exp_q.push_back(mk(1'b0, 1'b1, 24'h000010, 16'h00AA));
        exp_q.push_back(mk(1'b0, 1'b0, 24'h000401, 16'h0055));
        set_mcu(1'b0, 24'h000010, 8'h00);
        step();
        set_snes_rd(24'h000300);
        set_mcu(1'b1, 24'h000500, 8'hEE);
        step();
        cyc(1);
        set_snes_rd(24'h000401);
        step();
        cyc(22);
        chk("t5_rdy_after", 32'(bus.MCU_RDY), 32'h1);

        // 6: reset in the middle of a SNES write with an MCU request pending
        set_snes_wr(24'h000020, 8'h11, 1'b1);
        set_mcu(1'b1, 24'h000030, 8'h22);
        step();
        chk("t6_rdy_busy", 32'(bus.MCU_RDY), 32'h0);
        cyc(1);
        chk("t6_mid_we", {30'h0, bus.MEM_WE_N, bus.MEM_DQ_OE}, 32'h1);
        rst = 1'b1;
        cyc(1);
        chk("t6_rst_we_n",  32'(bus.MEM_WE_N), 32'h1);
        chk("t6_rst_dq_oe", 32'(bus.MEM_DQ_OE), 32'h0);
        chk("t6_rst_rdy",   32'(bus.MCU_RDY), 32'h1);
        chk("t6_rst_oe_n",  32'(bus.MEM_OE_N), 32'h1);
        cyc(1);
        rst = 1'b0;
        cyc(15);
        chk("t6_rdy_idle", 32'(bus.MCU_RDY), 32'h1);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
